// File: rtl/fetch_buffer.sv
// Instruction fetch stage: issues sequential IMEM reads, buffers tagged responses
// in a small FIFO, and hands them to decode; a redirect squashes everything in flight.
module fetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_enable,
  input  logic [ADDR_WIDTH-1:0]   redirect_address,
  output logic [ADDR_WIDTH-1:0]   imem_address,
  output logic                    imem_enable,
  input  logic [DATA_WIDTH-1:0]   imem_instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  squash_q, squash_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] pending_s;

  // Issue only when every buffered and in-flight fetch is guaranteed a slot
  always_comb begin
    pending_s = count_q + {{(CW-1){1'b0}}, inflight_q};
    issue_s   = reset & ~redirect_enable & (pending_s < CW'(DEPTH));
    push_s    = inflight_q & ~squash_q & ~redirect_enable;
    pop_s     = (count_q != {CW{1'b0}}) & out_ready & ~redirect_enable;
  end

  // Next-state for fetch pointer, in-flight tracking and FIFO bookkeeping
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    squash_d      = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect_enable) begin
      fetch_pc_d = redirect_address;
      squash_d   = inflight_q;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      inflight_d = issue_s;
      if (issue_s) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        inflight_pc_d = inflight_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= {ADDR_WIDTH{1'b0}};
      inflight_pc_q <= {ADDR_WIDTH{1'b0}};
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instruction;
    end
  end

  assign imem_enable     = issue_s;
  assign imem_address    = fetch_pc_q;
  assign out_valid       = (count_q != {CW{1'b0}});
  assign out_instruction = instr_mem_q[rd_ptr_q];
  assign out_pc          = pc_mem_q[rd_ptr_q];
  assign occupancy       = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations on the accepted stream.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_enable;
  logic [AW-1:0] redirect_address;
  logic [AW-1:0] imem_address;
  logic          imem_enable;
  logic [DW-1:0] imem_instruction = 16'h0000;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instruction;
  logic [AW-1:0] out_pc;
  logic [2:0]    occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] m_pc      = 16'h0000;
  logic [AW-1:0] m_pend_pc = 16'h0000;
  bit            m_pend    = 1'b0;
  logic [31:0]   q[$];
  logic [AW-1:0] acc_log[$];

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_enable  (redirect_enable),
    .redirect_address (redirect_address),
    .imem_address     (imem_address),
    .imem_enable      (imem_enable),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] imem_val(input logic [AW-1:0] a);
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) begin
    if (imem_enable) imem_instruction <= imem_val(imem_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [AW-1:0] exp);
    logic [31:0] act;
    act = (idx < acc_log.size()) ? {16'h0000, acc_log[idx]} : 32'hFFFF_FFFF;
    chk(name, act, {16'h0000, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model compare and advance, once per cycle away from the active edge
  always @(negedge clk) begin
    bit iss;
    if (!reset) begin
      m_pc   = 16'h0000;
      m_pend = 1'b0;
      q.delete();
    end
    iss = reset && !redirect_enable && ((q.size() + int'(m_pend)) < DEPTH);
    chk("m_imem_enable", {31'd0, imem_enable}, {31'd0, iss});
    chk("m_imem_address", {16'h0000, imem_address}, {16'h0000, m_pc});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    chk("m_occupancy", {29'd0, occupancy}, q.size());
    if (q.size() != 0) begin
      chk("m_out_pc", {16'h0000, out_pc}, {16'h0000, q[0][31:16]});
      chk("m_out_instr", {16'h0000, out_instruction}, {16'h0000, q[0][15:0]});
    end
    if (reset) begin
      if (!redirect_enable && out_valid && out_ready) acc_log.push_back(out_pc);
      if (redirect_enable) begin
        q.delete();
        m_pend = 1'b0;
        m_pc   = redirect_address;
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (m_pend) begin
          if (q.size() >= DEPTH) begin
            errors++;
            $display("FAIL push_to_full: occupancy %0d required below %0d", q.size(), DEPTH);
          end
          q.push_back({m_pend_pc, imem_val(m_pend_pc)});
        end
        m_pend = iss;
        if (iss) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 16'h0001;
        end
      end
    end
  end

  initial begin
    reset            = 1'b0;
    redirect_enable  = 1'b0;
    redirect_address = 16'h0000;
    out_ready        = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
    chk("rst_imem_enable", {31'd0, imem_enable}, 32'd0);
    chk("rst_imem_address", {16'h0000, imem_address}, 32'd0);

    // Reset release, streaming with ready high
    reset = 1'b1;
    #1;
    chk("first_issue_en", {31'd0, imem_enable}, 32'd1);
    chk("first_issue_addr", {16'h0000, imem_address}, 32'd0);
    tick();
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_pc", {16'h0000, out_pc}, 32'h0000);
    chk("c2_instr", {16'h0000, out_instruction}, 32'h1000);
    tick();
    chk("c3_pc", {16'h0000, out_pc}, 32'h0001);
    chk("c3_instr", {16'h0000, out_instruction}, 32'h1001);
    repeat (4) tick();

    // Reset mid-stream with entries buffered
    out_ready = 1'b0;
    tick();
    tick();
    chk("half_full", {31'd0, (occupancy >= 3'd2)}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_occupancy", {29'd0, occupancy}, 32'd0);
    chk("midrst_enable", {31'd0, imem_enable}, 32'd0);
    tick();

    // Backpressure from a fresh start
    reset = 1'b1;
    acc_log.delete();
    repeat (10) tick();
    chk("bp_occupancy", {29'd0, occupancy}, 32'd4);
    chk("bp_enable", {31'd0, imem_enable}, 32'd0);
    chk("bp_head_pc", {16'h0000, out_pc}, 32'h0000);
    chk("bp_head_instr", {16'h0000, out_instruction}, 32'h1000);
    out_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 8; i++) chk_log("bp_stream", i, AW'(i));

    // Redirect with three entries buffered and pc 3 in flight
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    chk("pre_redir_occ", {29'd0, occupancy}, 32'd3);
    redirect_enable  = 1'b1;
    redirect_address = 16'h0004;
    acc_log.delete();
    tick();
    redirect_enable = 1'b0;
    #1;
    chk("redir_occ", {29'd0, occupancy}, 32'd0);
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_issue_addr", {16'h0000, imem_address}, 32'h0004);
    tick();
    chk("redir_n2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("redir_n3_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_n3_pc", {16'h0000, out_pc}, 32'h0004);
    chk("redir_n3_instr", {16'h0000, out_instruction}, 32'h1004);
    out_ready = 1'b1;
    repeat (6) tick();
    chk_log("redir_stream0", 0, 16'h0004);
    chk_log("redir_stream1", 1, 16'h0005);

    // Redirect coinciding with a pop and a pending response
    chk("coinc_valid", {31'd0, out_valid}, 32'd1);
    redirect_enable  = 1'b1;
    redirect_address = 16'h0100;
    acc_log.delete();
    tick();
    redirect_enable = 1'b0;
    repeat (6) tick();
    chk_log("coinc_stream0", 0, 16'h0100);
    chk_log("coinc_stream1", 1, 16'h0101);
    chk_log("coinc_stream2", 2, 16'h0102);

    // Redirect held several cycles: last address wins
    acc_log.delete();
    redirect_enable  = 1'b1;
    redirect_address = 16'h0200;
    tick();
    redirect_address = 16'h0300;
    tick();
    redirect_address = 16'h0040;
    tick();
    redirect_enable = 1'b0;
    repeat (6) tick();
    chk_log("hold_stream0", 0, 16'h0040);
    chk_log("hold_stream1", 1, 16'h0041);

    // Address wrap
    acc_log.delete();
    redirect_enable  = 1'b1;
    redirect_address = 16'hFFFE;
    tick();
    redirect_enable = 1'b0;
    tick();
    tick();
    #1;
    chk("wrap_head_pc", {16'h0000, out_pc}, 32'hFFFE);
    chk("wrap_head_instr", {16'h0000, out_instruction}, 32'h0FFE);
    repeat (4) tick();
    chk_log("wrap_stream0", 0, 16'hFFFE);
    chk_log("wrap_stream1", 1, 16'hFFFF);
    chk_log("wrap_stream2", 2, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
